// File: rtl/custom_adder_pipe.sv
// Pipelined unsigned add/subtract of a zero-extended narrower operand B from A.
// The carry chain is cut into STAGES registered ripple segments with a stall-on-backpressure handshake.
module custom_adder_pipe #(
  parameter int WIDTH_A = 56,
  parameter int WIDTH_B = 55,
  parameter int STAGES  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] a,
  input  logic [WIDTH_B-1:0] b,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_A:0]   sum
);

  localparam int N    = WIDTH_A + 1;
  localparam int SEG  = (N + STAGES - 1) / STAGES;
  localparam int PIPE = (STAGES > 1) ? STAGES - 1 : 1;

  logic [N-1:0] a_ext;
  logic [N-1:0] b_ext;
  logic [N-1:0] b_eff;
  logic         stall;

  logic [N-1:0] pipe_a [PIPE];
  logic [N-1:0] pipe_b [PIPE];
  logic [N-1:0] pipe_s [PIPE];
  logic         pipe_c [PIPE];
  logic         pipe_v [PIPE];

  logic [N-1:0] stage_s [STAGES];
  logic         stage_c [STAGES];
  logic         last_v;

  logic [N-1:0] sum_q;
  logic         valid_q;

  assign a_ext     = {1'b0, a};
  assign b_ext     = {{(N-WIDTH_B){1'b0}}, b};
  assign b_eff     = sub ? ~b_ext : b_ext;
  assign stall     = valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = valid_q;
  assign sum       = sum_q;

  // Ripple-adds only the bits owned by segment k; all other sum bits pass through.
  // A segment may be empty for some parameter mixes, in which case the carry passes straight on.
  function automatic logic [N:0] seg_add(input logic [N-1:0] op_a,
                                         input logic [N-1:0] op_b,
                                         input logic [N-1:0] s_prev,
                                         input logic         cin,
                                         input int           k);
    logic [N-1:0] s;
    logic         c;
    s = s_prev;
    c = cin;
    for (int i = 0; i < N; i++) begin
      if (i >= k * SEG && i < (k + 1) * SEG) begin
        s[i] = op_a[i] ^ op_b[i] ^ c;
        c    = (op_a[i] & op_b[i]) | (op_a[i] & c) | (op_b[i] & c);
      end
    end
    return {c, s};
  endfunction

  // Stage 0 works straight off the ports; later stages work off the previous pipeline register.
  always_comb begin
    logic [N:0] res;
    res        = seg_add(a_ext, b_eff, '0, sub, 0);
    stage_s[0] = res[N-1:0];
    stage_c[0] = res[N];
    last_v     = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      res        = seg_add(pipe_a[k-1], pipe_b[k-1], pipe_s[k-1], pipe_c[k-1], k);
      stage_s[k] = res[N-1:0];
      stage_c[k] = res[N];
    end
    if (STAGES > 1) begin
      last_v = pipe_v[PIPE-1];
    end
  end

  // The whole pipeline freezes while the output is held; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      for (int k = 0; k < PIPE; k++) begin
        pipe_a[k] <= '0;
        pipe_b[k] <= '0;
        pipe_s[k] <= '0;
        pipe_c[k] <= 1'b0;
        pipe_v[k] <= 1'b0;
      end
    end else if (!stall) begin
      valid_q <= last_v;
      sum_q   <= stage_s[STAGES-1];
      if (STAGES > 1) begin
        pipe_a[0] <= a_ext;
        pipe_b[0] <= b_eff;
        pipe_s[0] <= stage_s[0];
        pipe_c[0] <= stage_c[0];
        pipe_v[0] <= in_valid;
        for (int k = 1; k < PIPE; k++) begin
          pipe_a[k] <= pipe_a[k-1];
          pipe_b[k] <= pipe_b[k-1];
          pipe_s[k] <= stage_s[k];
          pipe_c[k] <= stage_c[k];
          pipe_v[k] <= pipe_v[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_custom_adder_pipe.sv
// Scoreboard bench for custom_adder_pipe: default 56/55/4 instance plus an 8/5 sweep over STAGES 1, 3, 9.
module tb_custom_adder_pipe;

  localparam int WA = 56;
  localparam int WB = 55;
  localparam int ST = 4;
  localparam int N  = WA + 1;

  typedef struct {
    logic [63:0] exp;
    int          acc_edge;
    int          stalls;
  } sb_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          sub_i = 1'b0;
  logic [WA-1:0] a_i = '0;
  logic [WB-1:0] b_i = '0;
  logic          in_ready;
  logic          out_valid;
  logic [N-1:0]  sum;

  logic          sw_valid = 1'b0;
  logic          sw_sub = 1'b0;
  logic [7:0]    sw_a = '0;
  logic [4:0]    sw_b = '0;
  logic          sw_in_ready [3];
  logic          sw_out_valid [3];
  logic [8:0]    sw_sum [3];

  sb_t  sb[$];
  sb_t  sw_q[3][$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  logic prev_stall = 1'b0;
  logic [N-1:0] prev_sum = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  custom_adder_pipe #(.WIDTH_A(WA), .WIDTH_B(WB), .STAGES(ST)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_i), .b(b_i), .sub(sub_i), .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
  );

  custom_adder_pipe #(.WIDTH_A(8), .WIDTH_B(5), .STAGES(1)) u_sw1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[0]),
    .a(sw_a), .b(sw_b), .sub(sw_sub), .out_valid(sw_out_valid[0]), .out_ready(1'b1), .sum(sw_sum[0])
  );

  custom_adder_pipe #(.WIDTH_A(8), .WIDTH_B(5), .STAGES(3)) u_sw3 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[1]),
    .a(sw_a), .b(sw_b), .sub(sw_sub), .out_valid(sw_out_valid[1]), .out_ready(1'b1), .sum(sw_sum[1])
  );

  custom_adder_pipe #(.WIDTH_A(8), .WIDTH_B(5), .STAGES(9)) u_sw9 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[2]),
    .a(sw_a), .b(sw_b), .sub(sw_sub), .out_valid(sw_out_valid[2]), .out_ready(1'b1), .sum(sw_sum[2])
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] op_a, input logic [63:0] op_b,
                                        input logic s, input int n);
    logic [63:0] r;
    r = s ? (op_a - op_b) : (op_a + op_b);
    return r & ((64'd1 << n) - 64'd1);
  endfunction

  function automatic int swLat(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 9;
    endcase
  endfunction

  // Called just after a rising edge; holds the operands until they are accepted.
  task automatic applyStimulus(input logic [WA-1:0] op_a, input logic [WB-1:0] op_b, input logic s);
    logic ok;
    a_i      = op_a;
    b_i      = op_b;
    sub_i    = s;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    checkOutput("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on input transfer, pop and compare on output transfer, watch stalls.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      sb.delete();
      for (int i = 0; i < 3; i++) sw_q[i].delete();
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        e.exp      = model(64'(a_i), 64'(b_i), sub_i, N);
        e.acc_edge = cyc;
        e.stalls   = stall_cnt;
        sb.push_back(e);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("sum", 64'(sum), e.exp);
          checkOutput("latency", 64'(cyc - e.acc_edge), 64'(ST + stall_cnt - e.stalls));
        end
      end
      if (out_valid && !out_ready) begin
        checkOutput("in_ready_stall", 64'(in_ready), 64'd0);
        if (prev_stall) checkOutput("sum_hold", 64'(sum), 64'(prev_sum));
        stall_cnt++;
      end else begin
        checkOutput("in_ready_free", 64'(in_ready), 64'd1);
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;

      for (int i = 0; i < 3; i++) begin
        if (sw_valid) begin
          e.exp      = model(64'(sw_a), 64'(sw_b), sw_sub, 9);
          e.acc_edge = cyc;
          e.stalls   = 0;
          sw_q[i].push_back(e);
        end
        if (sw_out_valid[i]) begin
          if (sw_q[i].size() == 0) begin
            checkOutput("sw_unexpected_out", 64'(sw_out_valid[i]), 64'd0);
          end else begin
            e = sw_q[i].pop_front();
            checkOutput("sw_sum", 64'(sw_sum[i]), e.exp);
            checkOutput("sw_latency", 64'(cyc - e.acc_edge), 64'(swLat(i)));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] r1;
    logic [63:0] r2;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_sum", 64'(sum), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Carry rippling through every segment
    applyStimulus(56'hFF_FFFF_FFFF_FFFF, 55'h7F_FFFF_FFFF_FFFF, 1'b0);
    waitDrain();

    // Subtraction with and without borrow
    applyStimulus(56'd5, 55'd7, 1'b1);
    applyStimulus(56'd7, 55'd5, 1'b1);
    waitDrain();

    // Full-rate streaming
    for (int i = 0; i < 8; i++) applyStimulus(WA'(i), WB'(i + 1), 1'b0);
    waitDrain();

    // Backpressure held for five cycles after the first result leaves
    fork
      begin
        for (int i = 0; i < 6; i++) applyStimulus(WA'(100 + i), WB'(3 * i), i[0]);
      end
      begin
        for (int n = 0; n < 50; n++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();

    // Reset while three operations are in flight
    for (int i = 0; i < 3; i++) applyStimulus(WA'(1000 + i), WB'(i), 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checkOutput("post_rst_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(56'd123456789, 55'd987654, 1'b1);
    waitDrain();

    // Random operands, both operations
    for (int i = 0; i < 16; i++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      applyStimulus(r1[WA-1:0], r2[WB-1:0], r1[60]);
    end
    waitDrain();

    // Narrow sweep instances with random bubbles
    for (int i = 0; i < 40; i++) begin
      sw_a     = 8'($urandom());
      sw_b     = 5'($urandom());
      sw_sub   = 1'($urandom());
      sw_valid = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    sw_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) checkOutput("sw_drain", 64'(sw_q[i].size()), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
